// File: rtl/bcd_serial_converter.sv
// Iterative shift-and-add-3 binary-to-BCD converter with leading-zero blank flags.
// Converts one WIDTH-bit value per Start; results are registered and held between conversions.
module bcd_serial_converter #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [WIDTH-1:0]      Value,
  output logic                  Busy,
  output logic                  Done,
  output logic [4*DIGITS-1:0]   Digits,
  output logic [DIGITS-1:0]     Blank
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned SW = 4 * DIGITS;
  localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [WIDTH-1:0] shift_reg;
  logic [SW-1:0]   scratch;
  logic [SW-1:0]   scratch_adj;
  logic [CW-1:0]   count;
  logic [DIGITS-1:0] blank_next;

  // Per-nibble add-3 correction; nibbles never carry into each other.
  always_comb begin
    scratch_adj = scratch;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // Leading-zero chain from the top digit down; the units digit is never blanked.
  always_comb begin
    blank_next = '0;
    if (DIGITS > 1) begin
      blank_next[DIGITS-1] = (scratch[SW-1 -: 4] == 4'd0);
      for (int unsigned i = DIGITS - 1; i > 1; i--) begin
        blank_next[i-1] = (scratch[4*(i-1) +: 4] == 4'd0) && blank_next[i];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = SHIFT;
      SHIFT:   if (count == LAST_SHIFT) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      shift_reg <= '0;
      scratch   <= '0;
      count     <= '0;
      Done      <= 1'b0;
      Digits    <= '0;
      Blank     <= BLANK_RST;
    end else begin
      Done <= (state == FINISH);
      case (state)
        IDLE: begin
          if (Start) begin
            shift_reg <= Value;
            scratch   <= '0;
            count     <= '0;
          end
        end
        SHIFT: begin
          scratch   <= {scratch_adj[SW-2:0], shift_reg[WIDTH-1]};
          shift_reg <= shift_reg << 1;
          count     <= count + CW'(1);
        end
        FINISH: begin
          Digits <= scratch;
          Blank  <= blank_next;
        end
        default: ;
      endcase
    end
  end

  assign Busy = (state != IDLE);

endmodule

// File: tb/tb_bcd_serial_converter.sv
// Directed and randomized checks of bcd_serial_converter against a decimal reference model.
module tb_bcd_serial_converter;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned DIGITS = 5;

  logic                Clock;
  logic                Reset;
  logic                Start;
  logic [WIDTH-1:0]    Value;
  logic                Busy;
  logic                Done;
  logic [4*DIGITS-1:0] Digits;
  logic [DIGITS-1:0]   Blank;

  int checks = 0;
  int errors = 0;

  bcd_serial_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Start (Start),
    .Value (Value),
    .Busy  (Busy),
    .Done  (Done),
    .Digits(Digits),
    .Blank (Blank)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "simulation did not finish");
  end

  // Reference: decimal digits by repeated division.
  function automatic logic [4*DIGITS-1:0] ref_digits(input int unsigned v);
    logic [4*DIGITS-1:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Reference: digits at or above the decimal length of v are blanked, units never.
  function automatic logic [DIGITS-1:0] ref_blank(input int unsigned v);
    logic [DIGITS-1:0] b;
    int unsigned len;
    int unsigned x;
    len = 1;
    x = v / 10;
    while (x > 0) begin
      len++;
      x = x / 10;
    end
    b = '0;
    for (int i = 1; i < DIGITS; i++) b[i] = (i >= len);
    return b;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  // Launches a conversion from IDLE and follows it to Done.
  task automatic convert(input int unsigned v);
    int n;
    int busy_n;
    Value = WIDTH'(v);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    Value = WIDTH'($urandom);
    check("busy_after_accept", 64'(Busy), 64'(1));
    check("done_clear", 64'(Done), 64'(0));
    busy_n = 1;
    n = 0;
    while (Done !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (Done !== 1'b1 && Busy === 1'b1) busy_n++;
    end
    check("latency", 64'(n), 64'(17));
    check("busy_cycles", 64'(busy_n), 64'(17));
    check("busy_at_done", 64'(Busy), 64'(0));
    check("digits", 64'(Digits), 64'(ref_digits(v)));
    check("blank", 64'(Blank), 64'(ref_blank(v)));
  endtask

  initial begin
    int unsigned specials[6];
    int done_n;
    int done_at;
    specials = '{0, 9, 10, 99, 100, 65535};

    Reset = 1'b1;
    Start = 1'b0;
    Value = '0;
    #1;
    check("reset_busy", 64'(Busy), 64'(0));
    check("reset_done", 64'(Done), 64'(0));
    check("reset_digits", 64'(Digits), 64'(0));
    check("reset_blank", 64'(Blank), 64'(5'b11110));
    tick();
    tick();
    Reset = 1'b0;
    tick();

    // Zero still takes the full fixed latency.
    convert(0);
    check("zero_digits", 64'(Digits), 64'(20'h00000));
    check("zero_blank", 64'(Blank), 64'(5'b11110));
    tick();
    check("done_one_cycle", 64'(Done), 64'(0));

    convert(16'hFFFF);
    check("max_digits", 64'(Digits), 64'(20'h65535));
    check("max_blank", 64'(Blank), 64'(5'b00000));
    tick();
    convert(1203);
    check("v1203_digits", 64'(Digits), 64'(20'h01203));
    check("v1203_blank", 64'(Blank), 64'(5'b10000));
    tick();

    // Back-to-back: second Start lands on the Done cycle.
    convert(9);
    check("v9_digits", 64'(Digits), 64'(20'h00009));
    convert(10000);
    check("v10000_digits", 64'(Digits), 64'(20'h10000));
    check("v10000_blank", 64'(Blank), 64'(5'b00000));
    tick();

    // Starts during SHIFT and on the FINISH edge are dropped.
    Value = 16'd42;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    done_n = 0;
    done_at = 0;
    for (int t = 1; t <= 40; t++) begin
      Start = (t == 3 || t == 17);
      Value = Start ? 16'd999 : WIDTH'($urandom);
      tick();
      if (Done === 1'b1) begin
        done_n++;
        done_at = t;
      end
    end
    Start = 1'b0;
    check("ignored_done_count", 64'(done_n), 64'(1));
    check("ignored_done_at", 64'(done_at), 64'(17));
    check("ignored_digits", 64'(Digits), 64'(20'h00042));
    check("ignored_blank", 64'(Blank), 64'(5'b11100));
    check("ignored_idle", 64'(Busy), 64'(0));

    // Asynchronous abort mid-conversion.
    Value = 16'd500;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (7) tick();
    #2;
    Reset = 1'b1;
    #1;
    check("abort_busy", 64'(Busy), 64'(0));
    check("abort_done", 64'(Done), 64'(0));
    check("abort_digits", 64'(Digits), 64'(0));
    check("abort_blank", 64'(Blank), 64'(5'b11110));
    tick();
    Reset = 1'b0;
    done_n = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (Done === 1'b1) done_n++;
    end
    check("abort_no_done", 64'(done_n), 64'(0));
    check("abort_hold_digits", 64'(Digits), 64'(0));
    convert(7);
    check("after_abort_digits", 64'(Digits), 64'(20'h00007));
    tick();

    foreach (specials[i]) begin
      convert(specials[i]);
      tick();
    end
    for (int i = 0; i < 1000; i++) begin
      convert($urandom_range(0, 65535));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
